// File: rtl/reg_writeback_queue.sv
// In-order write-back queue for the MERC-16 register file: merges ALU and load-unit writes,
// drains one per cycle onto the single write port, and reports pending writes for hazard checks.
module reg_writeback_queue #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 4
) (
  input  logic                         Clock,
  input  logic                         Reset,
  input  logic                         AluValid,
  output logic                         AluReady,
  input  logic [ADDR_WIDTH-1:0]        AluAddr,
  input  logic [DATA_WIDTH-1:0]        AluData,
  input  logic                         MemValid,
  output logic                         MemReady,
  input  logic [ADDR_WIDTH-1:0]        MemAddr,
  input  logic [DATA_WIDTH-1:0]        MemData,
  output logic [ADDR_WIDTH-1:0]        WriteAddr,
  output logic [DATA_WIDTH-1:0]        WriteData,
  output logic                         WriteEnable,
  input  logic [ADDR_WIDTH-1:0]        QueryAddrA,
  input  logic [ADDR_WIDTH-1:0]        QueryAddrB,
  output logic                         PendingA,
  output logic                         PendingB,
  output logic [$clog2(DEPTH+1)-1:0]   Count,
  output logic                         Full,
  output logic                         Empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [DEPTH];

  logic [PW-1:0]         rd_ptr_reg;
  logic [PW-1:0]         wr_ptr_reg;
  logic [CW-1:0]         count_reg;
  logic                  we_reg;
  logic [ADDR_WIDTH-1:0] wa_reg;
  logic [DATA_WIDTH-1:0] wd_reg;

  logic                  mem_fire;
  logic                  alu_fire;
  logic                  push;
  logic                  pop;
  logic [ADDR_WIDTH-1:0] push_addr;
  logic [DATA_WIDTH-1:0] push_data;
  logic [DEPTH-1:0]      hit_a;
  logic [DEPTH-1:0]      hit_b;

  assign Full     = (count_reg == CW'(DEPTH));
  assign Empty    = (count_reg == '0);
  assign Count    = count_reg;
  assign MemReady = ~Reset & ~Full;
  // Loads are older than ALU results, so the load unit always wins a tie.
  assign AluReady = ~Reset & ~Full & ~MemValid;

  assign mem_fire  = MemValid & MemReady;
  assign alu_fire  = AluValid & AluReady;
  assign push_addr = mem_fire ? MemAddr : AluAddr;
  assign push_data = mem_fire ? MemData : AluData;
  // Writes to r0 are acknowledged but dropped; r0 is hardwired zero.
  assign push      = (mem_fire | alu_fire) & (push_addr != '0);
  assign pop       = (count_reg != '0);

  assign WriteEnable = we_reg;
  assign WriteAddr   = wa_reg;
  assign WriteData   = wd_reg;

  always_ff @(posedge Clock) begin
    if (push) begin
      addr_mem[wr_ptr_reg] <= push_addr;
      data_mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
      we_reg     <= 1'b0;
      wa_reg     <= '0;
      wd_reg     <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      if (pop) begin
        we_reg     <= 1'b1;
        wa_reg     <= addr_mem[rd_ptr_reg];
        wd_reg     <= data_mem[rd_ptr_reg];
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      end else begin
        we_reg <= 1'b0;
      end
      if (push & ~pop) begin
        count_reg <= count_reg + CW'(1);
      end else if (pop & ~push) begin
        count_reg <= count_reg - CW'(1);
      end
    end
  end

  // Entry gi counted from the head is live when it lies below the occupancy.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
    logic [PW-1:0] idx;
    logic          live;
    assign idx       = rd_ptr_reg + PW'(gi);
    assign live      = (CW'(gi) < count_reg);
    assign hit_a[gi] = live & (addr_mem[idx] == QueryAddrA);
    assign hit_b[gi] = live & (addr_mem[idx] == QueryAddrB);
  end

  assign PendingA = (QueryAddrA != '0) & ((|hit_a) | (we_reg & (wa_reg == QueryAddrA)));
  assign PendingB = (QueryAddrB != '0) & ((|hit_b) | (we_reg & (wa_reg == QueryAddrB)));

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Directed bench for reg_writeback_queue: a per-cycle vector table plus hand-written
// sequences for reset mid-queue, back-to-back streaming and pointer wrap-around.
module tb_reg_writeback_queue;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        AluValid, AluReady, MemValid, MemReady;
  logic [3:0]  AluAddr, MemAddr, WriteAddr, QueryAddrA, QueryAddrB;
  logic [15:0] AluData, MemData, WriteData;
  logic        WriteEnable, PendingA, PendingB, Full, Empty;
  logic [2:0]  Count;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [19:0] obs[$];
  logic [19:0] exp_q[$];
  int          max_count;
  logic        saw_full;
  logic        saw_not_ready;

  always #5 Clock = ~Clock;

  reg_writeback_queue #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .DEPTH(4)) dut (
    .Clock(Clock), .Reset(Reset),
    .AluValid(AluValid), .AluReady(AluReady), .AluAddr(AluAddr), .AluData(AluData),
    .MemValid(MemValid), .MemReady(MemReady), .MemAddr(MemAddr), .MemData(MemData),
    .WriteAddr(WriteAddr), .WriteData(WriteData), .WriteEnable(WriteEnable),
    .QueryAddrA(QueryAddrA), .QueryAddrB(QueryAddrB),
    .PendingA(PendingA), .PendingB(PendingB),
    .Count(Count), .Full(Full), .Empty(Empty)
  );

  typedef struct {
    logic        mv; logic [3:0] ma; logic [15:0] md;
    logic        av; logic [3:0] aa; logic [15:0] ad;
    logic [3:0]  qa; logic [3:0] qb;
    logic        mr; logic ar; logic we;
    logic [3:0]  wa; logic [15:0] wd;
    logic        pa; logic pb; logic [2:0] cnt;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(
    input logic mv, input logic [3:0] ma, input logic [15:0] md,
    input logic av, input logic [3:0] aa, input logic [15:0] ad,
    input logic [3:0] qa, input logic [3:0] qb,
    input logic mr, input logic ar, input logic we,
    input logic [3:0] wa, input logic [15:0] wd,
    input logic pa, input logic pb, input logic [2:0] cnt);
    vec_t v;
    v.mv = mv; v.ma = ma; v.md = md; v.av = av; v.aa = aa; v.ad = ad;
    v.qa = qa; v.qb = qb; v.mr = mr; v.ar = ar; v.we = we;
    v.wa = wa; v.wd = wd; v.pa = pa; v.pb = pb; v.cnt = cnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // One cycle: drive at the falling edge, sample 1 ns later, log any write-port activity.
  task automatic drive(input logic rst,
                       input logic mv, input logic [3:0] ma, input logic [15:0] md,
                       input logic av, input logic [3:0] aa, input logic [15:0] ad);
    @(negedge Clock);
    Reset = rst;
    MemValid = mv; MemAddr = ma; MemData = md;
    AluValid = av; AluAddr = aa; AluData = ad;
    #1;
    if (WriteEnable) obs.push_back({WriteAddr, WriteData});
    if (int'(Count) > max_count) max_count = int'(Count);
    if (Full) saw_full = 1'b1;
    if (!MemReady) saw_not_ready = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
  endtask

  task automatic compare_stream(input string name);
    check({name, "_len"}, obs.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < obs.size()) check($sformatf("%s_w%0d", name, i), obs[i], exp_q[i]);
    end
  endtask

  initial begin
    Reset = 1'b1;
    MemValid = 0; MemAddr = 0; MemData = 0;
    AluValid = 0; AluAddr = 0; AluData = 0;
    QueryAddrA = 0; QueryAddrB = 0;
    max_count = 0; saw_full = 0; saw_not_ready = 0;

    //                mv ma    md       av aa    ad       qa    qb    mr ar we wa    wd       pa pb cnt
    vecs[0]  = mk(0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 4'd5, 4'd0, 1, 1, 0, 4'd0, 16'h0000, 0, 0, 3'd0);
    vecs[1]  = mk(0, 4'd0, 16'h0000, 1, 4'd5, 16'h1234, 4'd5, 4'd0, 1, 1, 0, 4'd0, 16'h0000, 0, 0, 3'd0);
    vecs[2]  = mk(0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 4'd5, 4'd0, 1, 1, 0, 4'd0, 16'h0000, 1, 0, 3'd1);
    vecs[3]  = mk(0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 4'd5, 4'd0, 1, 1, 1, 4'd5, 16'h1234, 1, 0, 3'd0);
    vecs[4]  = mk(0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 4'd5, 4'd0, 1, 1, 0, 4'd5, 16'h1234, 0, 0, 3'd0);
    vecs[5]  = mk(1, 4'd2, 16'hAAAA, 1, 4'd3, 16'h5555, 4'd2, 4'd3, 1, 0, 0, 4'd5, 16'h1234, 0, 0, 3'd0);
    vecs[6]  = mk(0, 4'd0, 16'h0000, 1, 4'd3, 16'h5555, 4'd2, 4'd3, 1, 1, 0, 4'd5, 16'h1234, 1, 0, 3'd1);
    vecs[7]  = mk(0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 4'd2, 4'd3, 1, 1, 1, 4'd2, 16'hAAAA, 1, 1, 3'd1);
    vecs[8]  = mk(0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 4'd2, 4'd3, 1, 1, 1, 4'd3, 16'h5555, 0, 1, 3'd0);
    vecs[9]  = mk(0, 4'd0, 16'h0000, 1, 4'd0, 16'hFFFF, 4'd0, 4'd3, 1, 1, 0, 4'd3, 16'h5555, 0, 0, 3'd0);
    vecs[10] = mk(0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 4'd0, 4'd0, 1, 1, 0, 4'd3, 16'h5555, 0, 0, 3'd0);
    vecs[11] = mk(1, 4'd0, 16'h0BAD, 1, 4'd7, 16'h7777, 4'd7, 4'd0, 1, 0, 0, 4'd3, 16'h5555, 0, 0, 3'd0);
    vecs[12] = mk(0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 4'd7, 4'd0, 1, 1, 0, 4'd3, 16'h5555, 0, 0, 3'd0);

    // Reset and idle state
    drive(1'b1, 0, 4'd0, 16'h0, 0, 4'd0, 16'h0);
    check("rst_mem_ready", MemReady, 1'b0);
    check("rst_alu_ready", AluReady, 1'b0);
    drive(1'b1, 0, 4'd0, 16'h0, 0, 4'd0, 16'h0);
    idle(1);
    check("idle_we", WriteEnable, 1'b0);
    check("idle_count", Count, 3'd0);
    check("idle_empty", Empty, 1'b1);
    check("idle_full", Full, 1'b0);
    check("idle_mem_ready", MemReady, 1'b1);
    check("idle_alu_ready", AluReady, 1'b1);
    check("idle_waddr", WriteAddr, 4'd0);
    check("idle_wdata", WriteData, 16'h0);

    // Table: single write latency, Mem priority, r0 drop, pending flags
    for (int i = 0; i < 13; i++) begin
      QueryAddrA = vecs[i].qa;
      QueryAddrB = vecs[i].qb;
      drive(1'b0, vecs[i].mv, vecs[i].ma, vecs[i].md, vecs[i].av, vecs[i].aa, vecs[i].ad);
      $display("vec %0d: we=%0b wa=%0d wd=0x%0h cnt=%0d pa=%0b pb=%0b",
               i, WriteEnable, WriteAddr, WriteData, Count, PendingA, PendingB);
      check($sformatf("v%0d_mem_ready", i), MemReady, vecs[i].mr);
      check($sformatf("v%0d_alu_ready", i), AluReady, vecs[i].ar);
      check($sformatf("v%0d_we", i), WriteEnable, vecs[i].we);
      check($sformatf("v%0d_waddr", i), WriteAddr, vecs[i].wa);
      check($sformatf("v%0d_wdata", i), WriteData, vecs[i].wd);
      check($sformatf("v%0d_pend_a", i), PendingA, vecs[i].pa);
      check($sformatf("v%0d_pend_b", i), PendingB, vecs[i].pb);
      check($sformatf("v%0d_count", i), Count, vecs[i].cnt);
    end
    QueryAddrA = 0; QueryAddrB = 0;

    // Reset asserted with a write queued: everything is discarded
    drive(1'b0, 1'b1, 4'd9, 16'h9999, 1'b0, 4'd0, 16'h0);
    drive(1'b1, 1'b0, 4'd0, 16'h0, 1'b1, 4'd4, 16'h4444);
    check("midrst_alu_ready", AluReady, 1'b0);
    check("midrst_mem_ready", MemReady, 1'b0);
    drive(1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
    check("midrst_count", Count, 3'd0);
    check("midrst_we", WriteEnable, 1'b0);
    check("midrst_waddr", WriteAddr, 4'd0);
    check("midrst_wdata", WriteData, 16'h0);
    idle(2);
    check("midrst_no_late_write", WriteEnable, 1'b0);
    $display("mid-queue reset done");

    // Five back-to-back loads from empty: drained every cycle
    obs.delete(); exp_q.delete();
    max_count = 0; saw_full = 0; saw_not_ready = 0;
    for (int i = 1; i <= 5; i++) begin
      drive(1'b0, 1'b1, 4'(i), 16'(16'h0100 + i), 1'b0, 4'd0, 16'h0);
      exp_q.push_back({4'(i), 16'(16'h0100 + i)});
    end
    idle(3);
    compare_stream("burst5");
    check("burst5_max_count", max_count, 1);
    check("burst5_full_seen", saw_full, 1'b0);
    check("burst5_ready_drop", saw_not_ready, 1'b0);
    $display("burst of 5 observed %0d writes", obs.size());

    // Ten ALU writes wrap the pointers twice
    obs.delete(); exp_q.delete();
    for (int i = 1; i <= 10; i++) begin
      drive(1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 4'(i), 16'(i * 16'h11));
      exp_q.push_back({4'(i), 16'(i * 16'h11)});
    end
    idle(3);
    compare_stream("wrap10");
    check("wrap10_empty", Empty, 1'b1);
    check("wrap10_count", Count, 3'd0);
    $display("wrap of 10 observed %0d writes", obs.size());

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
